id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder/control unit.
- Latches the decoded control word and the operand data, and resolves the destination register.
- Detects load-use hazards against the instruction currently in EX, inserts bubbles, and honours branch/jump flushes and the memory-not-ready freeze.
- Holds a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width (register data, immediate, PC+4)
- CW, 32, bubble counter width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- MIO_ready  input  1  0 = memory busy; freeze the pipeline
- flush  input  1  branch/jump taken in ID; squash the ID instruction
- id_valid  input  1  ID holds a real instruction
- RegDst, ALUSrc_A, ALUSrc_B, RegWrite, mem_w, Jal  input  1 each  decoder control bits
- DatatoReg  input  2  00 ALU, 01 mem, 10 lui, 11 PC+4
- ALU_Control  input  3  ALU operation
- id_rs, id_rt, id_rd, id_shamt  input  5 each  instruction fields
- id_use_rs, id_use_rt  input  1 each  instruction reads rs/rt
- id_rs_data, id_rt_data, id_imm, id_pc4  input  DW each  operands
- ex_valid  output  1  EX holds a real instruction
- ex_RegDst, ex_ALUSrc_A, ex_ALUSrc_B, ex_RegWrite, ex_mem_w, ex_Jal  output  1 each  registered control
- ex_DatatoReg  output  2  registered
- ex_ALU_Control  output  3  registered
- ex_rs, ex_rt, ex_shamt  output  5 each  registered fields
- ex_wreg  output  5  resolved destination register
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  output  DW each  registered operands
- stall_if_id  output  1  hold PC and the IF/ID register this cycle
- bubble_cnt  output  CW  saturating count of inserted bubbles

Behaviour:
- Reset: when rst=1 at a clk edge, every ex_* output, ex_valid and bubble_cnt go to 0. Reset has priority over all other events, including mid-freeze and mid-stall.
- load_use (combinational) = ex_valid & ex_RegWrite & (ex_DatatoReg==01) & (ex_wreg!=0) & id_valid & ((id_use_rs & ex_wreg==id_rs) | (id_use_rt & ex_wreg==id_rt)).
- stall_if_id (combinational) = !MIO_ready | (load_use & !flush).
- Destination resolution, computed from ID inputs and then registered:
  - RegWrite & Jal → 31
  - else RegDst=1 → id_rd
  - else → id_rt
  - RegWrite=0 → 0
- Per-edge priority, rst excluded:
  1. HOLD: MIO_ready=0 → all ex_* unchanged, bubble_cnt unchanged. This applies even if flush or load_use is active.
  2. BUBBLE: flush=1, or load_use=1, or id_valid=0 → all ex_* cleared to 0 (ex_valid=0, ex_RegWrite=0, ex_mem_w=0), and all data fields cleared.
  3. LOAD: otherwise → capture all ID inputs and set ex_valid=1.
- bubble_cnt increments by 1 on each BUBBLE caused by flush or load_use. It does not count id_valid=0 and does not count HOLD. It saturates at all-ones with no wrap.
- flush and load_use active together: one bubble is inserted and stall_if_id=0, because the squashed instruction must not be replayed. The counter increments once.
- A load-use stall lasts exactly one cycle. The bubble clears ex_valid, so load_use drops on the next cycle and the instruction in ID then loads.
- Latency: one cycle from ID inputs to ex_* outputs.
- No combinational path from ID inputs to ex_* outputs. stall_if_id is the only combinational output.

Test Plan:
- Reset: drive all inputs non-zero, assert rst for 1 cycle → all outputs 0, bubble_cnt=0. Assert rst during a load-use stall → outputs 0 next cycle.
- Normal pass-through: add with RegDst=1, RegWrite=1, rd=5, rs_data=0x11, rt_data=0x22 → next cycle ex_valid=1, ex_wreg=5, ex_ALU_Control=010, data fields match. Jal with RegWrite=1 → ex_wreg=31. Store with RegWrite=0 → ex_wreg=0.
- Load-use: EX holds lw with ex_wreg=8; ID holds add with rs=8, id_use_rs=1 → stall_if_id=1 for exactly 1 cycle, bubble, bubble_cnt=1, then the add loads. Same case with ex_wreg=0 → no stall.
- Flush: flush=1 with a valid ID instruction → ex_valid=0, ex_mem_w=0, bubble_cnt+1, stall_if_id=0. flush and load_use together → single bubble, stall_if_id=0.
- Freeze: MIO_ready=0 for 3 cycles while flush=1 → ex_* constant, stall_if_id=1, bubble_cnt unchanged. MIO_ready returns to 1 → flush bubble taken on that edge.
- Saturation: CW=4, force 17 load-use bubbles → bubble_cnt stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands, resolves the
// destination register, inserts load-use/flush bubbles and counts them.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MIO_ready,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          RegDst,
  input  logic          ALUSrc_A,
  input  logic          ALUSrc_B,
  input  logic          RegWrite,
  input  logic          mem_w,
  input  logic          Jal,
  input  logic [1:0]    DatatoReg,
  input  logic [2:0]    ALU_Control,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  output logic          ex_valid,
  output logic          ex_RegDst,
  output logic          ex_ALUSrc_A,
  output logic          ex_ALUSrc_B,
  output logic          ex_RegWrite,
  output logic          ex_mem_w,
  output logic          ex_Jal,
  output logic [1:0]    ex_DatatoReg,
  output logic [2:0]    ex_ALU_Control,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_shamt,
  output logic [4:0]    ex_wreg,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic          stall_if_id,
  output logic [CW-1:0] bubble_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic       load_use_s;
  logic       bubble_s;
  logic       count_s;
  logic [4:0] wreg_s;

  // Load-use hazard detection and stall request
  always_comb begin
    load_use_s = ex_valid & ex_RegWrite & (ex_DatatoReg == 2'b01) & (ex_wreg != 5'd0) & id_valid &
                 ((id_use_rs & (ex_wreg == id_rs)) | (id_use_rt & (ex_wreg == id_rt)));
    // A flushed instruction is never replayed, so flush suppresses the load-use stall
    stall_if_id = ~MIO_ready | (load_use_s & ~flush);
    bubble_s    = flush | load_use_s | ~id_valid;
    count_s     = flush | load_use_s;
  end

  // Destination register resolution
  always_comb begin
    wreg_s = 5'd0;
    if (!RegWrite) begin
      wreg_s = 5'd0;
    end else if (Jal) begin
      wreg_s = 5'd31;
    end else if (RegDst) begin
      wreg_s = id_rd;
    end else begin
      wreg_s = id_rt;
    end
  end

  // Pipeline register: reset/bubble clears, freeze holds, otherwise load
  always_ff @(posedge clk) begin
    if (rst || (MIO_ready && bubble_s)) begin
      ex_valid       <= 1'b0;
      ex_RegDst      <= 1'b0;
      ex_ALUSrc_A    <= 1'b0;
      ex_ALUSrc_B    <= 1'b0;
      ex_RegWrite    <= 1'b0;
      ex_mem_w       <= 1'b0;
      ex_Jal         <= 1'b0;
      ex_DatatoReg   <= 2'b00;
      ex_ALU_Control <= 3'b000;
      ex_rs          <= 5'd0;
      ex_rt          <= 5'd0;
      ex_shamt       <= 5'd0;
      ex_wreg        <= 5'd0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
      ex_pc4         <= '0;
    end else if (MIO_ready) begin
      ex_valid       <= 1'b1;
      ex_RegDst      <= RegDst;
      ex_ALUSrc_A    <= ALUSrc_A;
      ex_ALUSrc_B    <= ALUSrc_B;
      ex_RegWrite    <= RegWrite;
      ex_mem_w       <= mem_w;
      ex_Jal         <= Jal;
      ex_DatatoReg   <= DatatoReg;
      ex_ALU_Control <= ALU_Control;
      ex_rs          <= id_rs;
      ex_rt          <= id_rt;
      ex_shamt       <= id_shamt;
      ex_wreg        <= wreg_s;
      ex_rs_data     <= id_rs_data;
      ex_rt_data     <= id_rt_data;
      ex_imm         <= id_imm;
      ex_pc4         <= id_pc4;
    end else begin
      ex_valid       <= ex_valid;
    end
  end

  // Saturating count of flush/load-use bubbles; frozen cycles are not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (MIO_ready && count_s && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (counter narrowed to 4 bits so
// saturation is reachable).
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, MIO_ready, flush, id_valid;
  logic          RegDst, ALUSrc_A, ALUSrc_B, RegWrite, mem_w, Jal;
  logic [1:0]    DatatoReg;
  logic [2:0]    ALU_Control;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic          id_use_rs, id_use_rt;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic          ex_valid, ex_RegDst, ex_ALUSrc_A, ex_ALUSrc_B, ex_RegWrite, ex_mem_w, ex_Jal;
  logic [1:0]    ex_DatatoReg;
  logic [2:0]    ex_ALU_Control;
  logic [4:0]    ex_rs, ex_rt, ex_shamt, ex_wreg;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic          stall_if_id;
  logic [CW-1:0] bubble_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .MIO_ready(MIO_ready), .flush(flush), .id_valid(id_valid),
    .RegDst(RegDst), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite),
    .mem_w(mem_w), .Jal(Jal), .DatatoReg(DatatoReg), .ALU_Control(ALU_Control),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc_A(ex_ALUSrc_A),
    .ex_ALUSrc_B(ex_ALUSrc_B), .ex_RegWrite(ex_RegWrite), .ex_mem_w(ex_mem_w),
    .ex_Jal(ex_Jal), .ex_DatatoReg(ex_DatatoReg), .ex_ALU_Control(ex_ALU_Control),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt), .ex_wreg(ex_wreg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic regdst, input logic regwrite, input logic jal,
                         input logic memw, input logic [1:0] dtr, input logic [2:0] aluc);
    RegDst = regdst; RegWrite = regwrite; Jal = jal; mem_w = memw;
    DatatoReg = dtr; ALU_Control = aluc;
  endtask

  task automatic set_ops(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt,
                         input logic [31:0] rsd, input logic [31:0] rtd);
    id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd;
  endtask

  initial begin
    // Everything non-zero under reset
    rst = 1'b1; MIO_ready = 1'b1; flush = 1'b1; id_valid = 1'b1;
    ALUSrc_A = 1'b1; ALUSrc_B = 1'b1; id_shamt = 5'd7;
    id_imm = 32'hFFFF_0001; id_pc4 = 32'h0000_0104;
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 3'b111);
    set_ops(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_wreg", 32'(ex_wreg), 32'd0);
    chk("rst_ctl", {25'd0, ex_RegWrite, ex_mem_w, ex_Jal, ex_DatatoReg, ex_ALUSrc_A, ex_ALUSrc_B}, 32'd0);
    chk("rst_alu", 32'(ex_ALU_Control), 32'd0);
    chk("rst_data", ex_rs_data | ex_rt_data | ex_imm | ex_pc4, 32'd0);
    chk("rst_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_stall", 32'(stall_if_id), 32'd0);

    // add r5 = r1 + r2
    rst = 1'b0; flush = 1'b0; ALUSrc_A = 1'b0; ALUSrc_B = 1'b1; id_shamt = 5'd3;
    id_imm = 32'h0000_1234; id_pc4 = 32'h0000_0040;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h11, 32'h22);
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_wreg", 32'(ex_wreg), 32'd5);
    chk("add_alu", 32'(ex_ALU_Control), 32'd2);
    chk("add_rsd", ex_rs_data, 32'h11);
    chk("add_rtd", ex_rt_data, 32'h22);
    chk("add_imm", ex_imm, 32'h0000_1234);
    chk("add_pc4", ex_pc4, 32'h0000_0040);
    chk("add_fields", {17'd0, ex_rs, ex_rt, ex_shamt}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("add_srcb", 32'({ex_ALUSrc_A, ex_ALUSrc_B}), 32'd1);

    // jal -> r31
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 3'b000);
    set_ops(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("jal_wreg", 32'(ex_wreg), 32'd31);
    chk("jal_ctl", 32'({ex_Jal, ex_DatatoReg}), 32'd7);

    // store: no destination
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010);
    set_ops(5'd2, 5'd4, 5'd9, 1'b1, 1'b1, 32'h100, 32'hBEEF);
    tick();
    chk("sw_wreg", 32'(ex_wreg), 32'd0);
    chk("sw_memw", 32'({ex_mem_w, ex_RegWrite}), 32'd2);

    // I-type writes rt
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd2, 5'd6, 5'd9, 1'b1, 1'b0, 32'h1, 32'h2);
    tick();
    chk("itype_wreg", 32'(ex_wreg), 32'd6);

    // lw r8 then dependent add: one bubble, then the add loads
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010);
    set_ops(5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    chk("lw_wreg", 32'(ex_wreg), 32'd8);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 32'h55, 32'h66);
    #1;
    chk("lu_stall", 32'(stall_if_id), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_bub_rw", 32'({ex_RegWrite, ex_wreg}), 32'd0);
    chk("lu_bub_data", ex_rs_data, 32'd0);
    chk("lu_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_stall_drop", 32'(stall_if_id), 32'd0);
    tick();
    chk("lu_load_valid", 32'(ex_valid), 32'd1);
    chk("lu_load_wreg", 32'(ex_wreg), 32'd10);
    chk("lu_load_rsd", ex_rs_data, 32'h55);
    chk("lu_load_cnt", 32'(bubble_cnt), 32'd1);

    // lw with destination r0 is not a hazard
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010);
    set_ops(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h77, 32'h0);
    #1;
    chk("r0_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("r0_valid", 32'(ex_valid), 32'd1);
    chk("r0_cnt", 32'(bubble_cnt), 32'd1);

    // flush of a valid store
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010);
    set_ops(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 32'h1, 32'h2);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_memw", 32'(ex_mem_w), 32'd0);
    chk("fl_cnt", 32'(bubble_cnt), 32'd2);

    // flush and load-use together: single bubble, no stall
    flush = 1'b0;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010);
    set_ops(5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd4, 5'd8, 5'd12, 1'b1, 1'b1, 32'h99, 32'h98);
    flush = 1'b1;
    #1;
    chk("fllu_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("fllu_valid", 32'(ex_valid), 32'd0);
    chk("fllu_cnt", 32'(bubble_cnt), 32'd3);
    flush = 1'b0;
    tick();
    chk("fllu_next_wreg", 32'(ex_wreg), 32'd12);
    chk("fllu_next_cnt", 32'(bubble_cnt), 32'd3);

    // freeze for 3 cycles with flush pending
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3'b110);
    set_ops(5'd1, 5'd1, 5'd20, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF);
    flush = 1'b1; MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stall", 32'(stall_if_id), 32'd1);
      tick();
      chk("frz_valid", 32'(ex_valid), 32'd1);
      chk("frz_wreg", 32'(ex_wreg), 32'd12);
      chk("frz_rsd", ex_rs_data, 32'h99);
      chk("frz_cnt", 32'(bubble_cnt), 32'd3);
    end
    MIO_ready = 1'b1;
    #1;
    chk("thaw_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("thaw_valid", 32'(ex_valid), 32'd0);
    chk("thaw_cnt", 32'(bubble_cnt), 32'd4);

    // reset during a load-use stall
    flush = 1'b0;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010);
    set_ops(5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
    set_ops(5'd5, 5'd8, 5'd13, 1'b0, 1'b1, 32'h1, 32'h2);
    #1;
    chk("rstlu_stall", 32'(stall_if_id), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstlu_valid", 32'(ex_valid), 32'd0);
    chk("rstlu_wreg", 32'(ex_wreg), 32'd0);
    chk("rstlu_cnt", 32'(bubble_cnt), 32'd0);
    rst = 1'b0;

    // 17 load-use bubbles into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010);
      set_ops(5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010);
      set_ops(5'd8, 5'd2, 5'd14, 1'b1, 1'b1, 32'h0, 32'h0);
      tick();
      chk("sat_cnt", 32'(bubble_cnt), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    chk("sat_final", 32'(bubble_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
